// File: rtl/arm_loader_pkg.sv
// Shared definitions for the ARM memory loader: FSM state encoding, header
// field positions and the END token.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package arm_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } ld_state_e;

  localparam int TGT_BIT  = 31;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 16;
  localparam int CNT_MSB  = 15;
  localparam int CNT_LSB  = 0;

  localparam logic [31:0] END_TOKEN = 32'hFFFF_FFFF;

endpackage

// File: rtl/arm_mem_loader.sv
// Purpose : loads a 32-bit header/data word stream into instruction/data memory, holds the core until END.
// Latency : memory write strobe/addr/wdata registered, valid the cycle after the accepting transfer.
// Backpr. : in_ready high in HDR/DATA/CHK (1 word/clk), low in RUN/ERR (terminal until rst).
// Ports   : clk/rst (async active-high); in_valid/in_ready/in_data stream in;
//           ins_we/ins_addr/ins_wdata and dmem_we/dmem_addr/dmem_wdata memory write ports;
//           cpu_hold (core reset), done (END accepted), err (sticky protocol error).
// Macro   : LOADER_CHECKSUM_EN adds a trailer word per block that must equal the mod-2^32 data sum.
module arm_mem_loader
  import arm_loader_pkg::*;
#(
  parameter int INS_MEM_SIZE  = 32,
  parameter int DATA_MEM_SIZE = 64,
  parameter int IADDR_W       = 5,
  parameter int DADDR_W       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               ins_we,
  output logic [IADDR_W-1:0] ins_addr,
  output logic [31:0]        ins_wdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  // Depths widened by one bit so an 8-bit header address compares cleanly.
  localparam logic [8:0] INS_LIM  = 9'(INS_MEM_SIZE);
  localparam logic [8:0] DATA_LIM = 9'(DATA_MEM_SIZE);

  ld_state_e          state_q, state_d;
  logic               tgt_q, tgt_d;          // 0 = instruction memory, 1 = data memory
  logic [7:0]         addr_q, addr_d;        // start + k for the next data word
  logic [15:0]        rem_q, rem_d;          // words still expected in the block
  logic               in_ready_q, in_ready_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ins_we_q, ins_we_d;
  logic               dmem_we_q, dmem_we_d;
  logic [IADDR_W-1:0] ins_addr_q, ins_addr_d;
  logic [DADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]        wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]        sum_q, sum_d;
`endif

  logic       xfer;
  logic       hdr_tgt;
  logic [7:0] hdr_addr;
  logic [15:0] hdr_cnt;

  assign xfer     = in_valid & in_ready_q;
  assign hdr_tgt  = in_data[TGT_BIT];
  assign hdr_addr = in_data[ADDR_MSB:ADDR_LSB];
  assign hdr_cnt  = in_data[CNT_MSB:CNT_LSB];

  function automatic logic out_of_range(input logic tgt, input logic [7:0] a);
    return tgt ? ({1'b0, a} >= DATA_LIM) : ({1'b0, a} >= INS_LIM);
  endfunction

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    ins_we_d    = 1'b0;
    dmem_we_d   = 1'b0;
    ins_addr_d  = ins_addr_q;
    dmem_addr_d = dmem_addr_q;
    wdata_d     = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          // END is checked first: its address field (0xFF) would otherwise read as out of range.
          if (in_data == END_TOKEN) begin
            state_d = ST_RUN;
          end else if (out_of_range(hdr_tgt, hdr_addr)) begin
            state_d = ST_ERR;
          end else begin
            tgt_d  = hdr_tgt;
            addr_d = hdr_addr;
            rem_d  = hdr_cnt;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = 32'd0;
            // An empty block still carries a (zero) trailer.
            state_d = (hdr_cnt != 16'd0) ? ST_DATA : ST_CHK;
`else
            state_d = (hdr_cnt != 16'd0) ? ST_DATA : ST_HDR;
`endif
          end
        end
      end

      ST_DATA: begin
        if (xfer) begin
          if (out_of_range(tgt_q, addr_q)) begin
            // Overflowing word is dropped; earlier words of the block stay written.
            state_d = ST_ERR;
          end else begin
            ins_we_d    = ~tgt_q;
            dmem_we_d   = tgt_q;
            ins_addr_d  = addr_q[IADDR_W-1:0];
            dmem_addr_d = addr_q[DADDR_W-1:0];
            wdata_d     = in_data;
            addr_d      = addr_q + 8'd1;
            rem_d       = rem_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_d = sum_q + in_data;
            if (rem_q == 16'd1) state_d = ST_CHK;
`else
            if (rem_q == 16'd1) state_d = ST_HDR;
`endif
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) state_d = (in_data == sum_q) ? ST_HDR : ST_ERR;
      end
`endif

      ST_RUN: state_d = ST_RUN;
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    // Status outputs are registered copies of the next-state decode.
    in_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_hold_d = (state_d != ST_RUN);
    done_d     = (state_d == ST_RUN);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HDR;
      tgt_q       <= 1'b0;
      addr_q      <= 8'd0;
      rem_q       <= 16'd0;
      in_ready_q  <= 1'b1;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ins_we_q    <= 1'b0;
      dmem_we_q   <= 1'b0;
      ins_addr_q  <= '0;
      dmem_addr_q <= '0;
      wdata_q     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ins_we_q    <= ins_we_d;
      dmem_we_q   <= dmem_we_d;
      ins_addr_q  <= ins_addr_d;
      dmem_addr_q <= dmem_addr_d;
      wdata_q     <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ins_we     = ins_we_q;
  assign ins_addr   = ins_addr_q;
  assign ins_wdata  = wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_arm_mem_loader.sv
// Scoreboard bench for arm_mem_loader: expected memory writes are queued as
// words are driven and checked (target, address, data, cycle) as strobes appear.
module tb_arm_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        ins_we;
  logic [4:0]  ins_addr;
  logic [31:0] ins_wdata;
  logic        dmem_we;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  arm_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ins_we     (ins_we),
    .ins_addr   (ins_addr),
    .ins_wdata  (ins_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tgt;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_wr_t;

  exp_wr_t sb[$];
  int      cyc = 0;
  int      errors = 0;
  int      checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (ins_we || dmem_we)) begin
      check("one_strobe", {31'd0, ins_we & dmem_we}, 32'd0);
      check("write_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_wr_t e;
        e = sb.pop_front();
        check("wr_target", {31'd0, dmem_we}, {31'd0, e.tgt});
        if (dmem_we) begin
          check("wr_addr", {26'd0, dmem_addr}, {24'd0, e.addr});
          check("wr_data", dmem_wdata, e.data);
        end else begin
          check("wr_addr", {27'd0, ins_addr}, {24'd0, e.addr});
          check("wr_data", ins_wdata, e.data);
        end
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one word for one cycle; optionally queue the write it must cause.
  task automatic send(input logic [31:0] w, input bit exp_we = 0,
                      input logic tgt = 0, input logic [7:0] addr = 8'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    if (exp_we) sb.push_back('{tgt: tgt, addr: addr, data: w, cyc: cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'hDEAD_BEEF;
    end
  endtask

  // Checksum trailer; absent in the default build.
  task automatic trailer(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    send(s);
`else
    if (s === 32'hx) $display("unreachable");
`endif
  endtask

  task automatic drain(input string tag);
    idle(2);
    check(tag, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'd0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({pfx, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({pfx, "_done"}, {31'd0, done}, 32'd0);
    check({pfx, "_err"}, {31'd0, err}, 32'd0);
    check({pfx, "_strobes"}, {30'd0, ins_we, dmem_we}, 32'd0);
    check({pfx, "_addrs"}, {21'd0, ins_addr, dmem_addr}, 32'd0);
    check({pfx, "_wdata"}, ins_wdata | dmem_wdata, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'd0;

    // Reset values.
    do_reset();
    check_reset_values("rst");

    // Instruction block, back-to-back at addresses 0..2.
    send(32'h0000_0003);
    send(32'hAAAA_0001, 1, 1'b0, 8'd0);
    send(32'hBBBB_0002, 1, 1'b0, 8'd1);
    send(32'hCCCC_0003, 1, 1'b0, 8'd2);
    trailer(32'hAAAA_0001 + 32'hBBBB_0002 + 32'hCCCC_0003);
    drain("ins_blk_drain");
    check("ins_blk_hold", {31'd0, cpu_hold}, 32'd1);
    check("ins_blk_done", {31'd0, done}, 32'd0);
    check("ins_blk_ready", {31'd0, in_ready}, 32'd1);

    // Data block at 5..6 then END.
    do_reset();
    send(32'h8005_0002);
    send(32'h0000_0011, 1, 1'b1, 8'd5);
    send(32'h0000_0022, 1, 1'b1, 8'd6);
    trailer(32'h0000_0033);
    send(32'hFFFF_FFFF);
    idle(1);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_hold", {31'd0, cpu_hold}, 32'd0);
    check("end_ready", {31'd0, in_ready}, 32'd0);
    check("end_err", {31'd0, err}, 32'd0);
    drain("end_drain");

    // Instruction overflow: start 31, second word dropped.
    do_reset();
    send(32'h001F_0002);
    send(32'h1234_5678, 1, 1'b0, 8'd31);
    send(32'h8765_4321);
    idle(1);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_hold", {31'd0, cpu_hold}, 32'd1);
    send(32'h0000_0001);  // ignored: not ready
    drain("ovf_drain");
    check("ovf_err_sticky", {31'd0, err}, 32'd1);

    // Data overflow at depth 64.
    do_reset();
    send(32'h803F_0002);
    send(32'h0000_0063, 1, 1'b1, 8'd63);
    send(32'h0000_0064);
    idle(1);
    check("dovf_err", {31'd0, err}, 32'd1);
    drain("dovf_drain");

    // Header start already out of range (data 64, ins 32).
    do_reset();
    send(32'h8040_0001);
    idle(1);
    check("dhdr_bad_err", {31'd0, err}, 32'd1);
    do_reset();
    send(32'h0020_0001);
    idle(1);
    check("ihdr_bad_err", {31'd0, err}, 32'd1);
    drain("hdr_bad_drain");

    // Empty block then END: no writes at all.
    do_reset();
    send(32'h0000_0000);
    trailer(32'd0);
    send(32'hFFFF_FFFF);
    idle(1);
    check("empty_done", {31'd0, done}, 32'd1);
    drain("empty_drain");

    // Valid gaps mid-block, then reset mid-block.
    do_reset();
    send(32'h0004_0003);
    send(32'h5555_0001, 1, 1'b0, 8'd4);
    idle(2);
    send(32'h5555_0002, 1, 1'b0, 8'd5);
    idle(3);
    check("gap_sb", sb.size(), 32'd0);
    do_reset();
    check_reset_values("midrst");
    // Back in HDR: this header must start a fresh block at address 0.
    send(32'h0000_0001);
    send(32'h7777_0000, 1, 1'b0, 8'd0);
    trailer(32'h7777_0000);
    drain("midrst_drain");
    check("midrst_ready", {31'd0, in_ready}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send(32'h8000_0002);
    send(32'd1, 1, 1'b1, 8'd0);
    send(32'd2, 1, 1'b1, 8'd1);
    send(32'd3);
    idle(1);
    check("chk_ok_err", {31'd0, err}, 32'd0);
    check("chk_ok_ready", {31'd0, in_ready}, 32'd1);
    send(32'h8000_0002);
    send(32'd1, 1, 1'b1, 8'd0);
    send(32'd2, 1, 1'b1, 8'd1);
    send(32'd4);
    idle(1);
    check("chk_bad_err", {31'd0, err}, 32'd1);
    drain("chk_drain");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
